// File: rtl/ssd1306_pkg.sv
// ssd1306_pkg: SSD1306 command opcodes shared by the SPI receive checker,
// the init-sequence ROM generator and the init sequencer, plus the
// command decoder state type.
//   CMD_*           command opcodes
//   CONTRAST_RESET  contrast register value after display reset
//   dec_state_t     command decoder states
//   takes_skip_arg  1 for commands whose single argument the decoder ignores
package ssd1306_pkg;

  localparam logic [7:0] CMD_DISPLAY_OFF   = 8'hAE;
  localparam logic [7:0] CMD_DISPLAY_ON    = 8'hAF;
  localparam logic [7:0] CMD_NORMAL        = 8'hA6;
  localparam logic [7:0] CMD_INVERT        = 8'hA7;
  localparam logic [7:0] CMD_SET_CONTRAST  = 8'h81;
  localparam logic [7:0] CMD_CHARGE_PUMP   = 8'h8D;
  localparam logic [7:0] CMD_SET_OFFSET    = 8'hD3;
  localparam logic [7:0] CMD_SET_COM_PINS  = 8'hDA;
  localparam logic [7:0] CMD_SET_CLK_DIV   = 8'hD5;
  localparam logic [7:0] CMD_SET_PRECHARGE = 8'hD9;
  localparam logic [7:0] CMD_SET_MUX       = 8'hA8;
  localparam logic [7:0] CMD_SET_VCOMH     = 8'hDB;

  localparam logic [7:0] CONTRAST_RESET    = 8'h7F;

  typedef enum logic [1:0] {
    DEC_IDLE,
    DEC_ARG_CONTRAST,
    DEC_ARG_PUMP,
    DEC_ARG_SKIP
  } dec_state_t;

  function automatic logic takes_skip_arg(input logic [7:0] op);
    return (op == CMD_SET_OFFSET)    || (op == CMD_SET_COM_PINS) ||
           (op == CMD_SET_CLK_DIV)   || (op == CMD_SET_PRECHARGE) ||
           (op == CMD_SET_MUX)       || (op == CMD_SET_VCOMH);
  endfunction

endpackage

// File: rtl/ssd1306_spi_rx_if.sv
// ssd1306_spi_rx_if: 4-wire OLED link pins plus the received-byte stream.
//   oled_sclk/oled_sdin/ss/oled_dc/oled_res  SPI link driven by the master side
//   byte_data/byte_dc/byte_valid             FIFO head presented by the receiver
//   byte_ready                               consumer accept
// master: SPI master + byte consumer.  slave: the receiver.
interface ssd1306_spi_rx_if;
  logic       oled_sclk;
  logic       oled_sdin;
  logic       ss;
  logic       oled_dc;
  logic       oled_res;
  logic [7:0] byte_data;
  logic       byte_dc;
  logic       byte_valid;
  logic       byte_ready;

  modport master (
    output oled_sclk, oled_sdin, ss, oled_dc, oled_res, byte_ready,
    input  byte_data, byte_dc, byte_valid
  );

  modport slave (
    input  oled_sclk, oled_sdin, ss, oled_dc, oled_res, byte_ready,
    output byte_data, byte_dc, byte_valid
  );
endinterface

// File: rtl/ssd1306_rx_fifo.sv
// ssd1306_rx_fifo: first-word fall-through FIFO for received {dc, byte} words.
//   clk_50M, rst_n  clock, async active-low reset
//   flush           empties the FIFO (wins over push)
//   push/push_data  write request; dropped when full unless a pop frees a slot
//   pop             read request, ignored when empty
//   head            current head word, 0 when empty
//   empty/full      occupancy flags
//   drop            pulses when a push is discarded because the FIFO is full
module ssd1306_rx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 9
) (
  input  logic             clk_50M,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full,
  output logic             drop
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra pointer bit distinguishes full from empty.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A simultaneous pop frees the slot being written, so push is honoured when full.
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop && !flush;
  assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_50M) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/ssd1306_spi_rx.sv
// ssd1306_spi_rx: SSD1306-side model of the 4-wire OLED SPI link (mode 3).
// Assembles bytes from the synchronized SPI pins, tags them with D/C, queues
// them in a FWFT FIFO and tracks the display state set by commands.
//   clk_50M, rst_n   system clock, async active-low reset
//   spi              link pins in, received byte stream out (slave modport)
//   err_clr          clears overflow and frame_err
//   display_on       1 after 0xAF, 0 after 0xAE
//   inverted         1 after 0xA7, 0 after 0xA6
//   contrast         argument of the last 0x81
//   charge_pump_en   bit 2 of the last 0x8D argument
//   overflow         sticky: byte dropped on a full FIFO
//   frame_err        sticky: ss released mid-byte
//
// Decoder states:
//   state            | meaning
//   DEC_IDLE         | waiting for an opcode
//   DEC_ARG_CONTRAST | next command byte is the contrast value
//   DEC_ARG_PUMP     | next command byte is the charge pump setting (bit 2)
//   DEC_ARG_SKIP     | next command byte is an argument we do not track
module ssd1306_spi_rx
  import ssd1306_pkg::*;
#(
  parameter int unsigned LSB_FIRST   = 1,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk_50M,
  input  logic                 rst_n,
  ssd1306_spi_rx_if.slave      spi,
  input  logic                 err_clr,
  output logic                 display_on,
  output logic                 inverted,
  output logic [7:0]           contrast,
  output logic                 charge_pump_en,
  output logic                 overflow,
  output logic                 frame_err
);

  // Synchronizer word layout: {res, ss, dc, sdin, sclk}; idle levels res=1, ss=1, sclk=1.
  localparam logic [4:0] SYNC_IDLE = 5'b11001;

  logic [4:0] sync_pipe [SYNC_STAGES];
  logic       sclk_s, sdin_s, dc_s, ss_s, res_s;
  logic       sclk_q, ss_q;
  logic       sclk_rise, ss_rise;

  logic [2:0] bit_cnt;
  logic [7:0] shift_reg;
  logic [7:0] shift_next;
  logic       push_valid;
  logic [7:0] push_data;
  logic       push_dc;

  logic       fifo_empty, fifo_full, fifo_drop;
  logic [8:0] fifo_head;
  logic       fifo_push, fifo_pop;
  logic       cmd_strobe;
  logic       frame_err_set;

  dec_state_t dec_state;

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_pipe[i] <= SYNC_IDLE;
    end else begin
      sync_pipe[0] <= {spi.oled_res, spi.ss, spi.oled_dc, spi.oled_sdin, spi.oled_sclk};
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_pipe[i] <= sync_pipe[i-1];
    end
  end

  assign {res_s, ss_s, dc_s, sdin_s, sclk_s} = sync_pipe[SYNC_STAGES-1];

  assign sclk_rise  = sclk_s && !sclk_q;
  assign ss_rise    = ss_s && !ss_q;
  assign shift_next = (LSB_FIRST != 0) ? {sdin_s, shift_reg[7:1]}
                                       : {shift_reg[6:0], sdin_s};

  // Display reset drops a partial byte silently, so frame errors need res high.
  assign frame_err_set = ss_rise && (bit_cnt != 3'd0) && res_s;

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q     <= 1'b1;
      ss_q       <= 1'b1;
      bit_cnt    <= 3'd0;
      shift_reg  <= 8'h00;
      push_valid <= 1'b0;
      push_data  <= 8'h00;
      push_dc    <= 1'b0;
    end else begin
      sclk_q     <= sclk_s;
      ss_q       <= ss_s;
      push_valid <= 1'b0;
      if (!res_s || ss_s) begin
        bit_cnt <= 3'd0;
      end else if (sclk_rise) begin
        shift_reg <= shift_next;
        bit_cnt   <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          push_valid <= 1'b1;
          push_data  <= shift_next;
          push_dc    <= dc_s;
        end
      end
    end
  end

  assign fifo_push = push_valid && res_s;
  assign fifo_pop  = !fifo_empty && spi.byte_ready;

  ssd1306_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (9)
  ) u_fifo (
    .clk_50M   (clk_50M),
    .rst_n     (rst_n),
    .flush     (!res_s),
    .push      (fifo_push),
    .push_data ({push_dc, push_data}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .drop      (fifo_drop)
  );

  assign spi.byte_data  = fifo_head[7:0];
  assign spi.byte_dc    = fifo_head[8];
  assign spi.byte_valid = !fifo_empty;

  // A set in the same cycle as err_clr keeps the flag high.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overflow  <= fifo_drop     || (overflow  && !err_clr);
      frame_err <= frame_err_set || (frame_err && !err_clr);
    end
  end

  // Decoder sees every command byte at push time, even ones the FIFO drops.
  assign cmd_strobe = push_valid && !push_dc;

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      dec_state      <= DEC_IDLE;
      display_on     <= 1'b0;
      inverted       <= 1'b0;
      contrast       <= CONTRAST_RESET;
      charge_pump_en <= 1'b0;
    end else if (!res_s) begin
      dec_state      <= DEC_IDLE;
      display_on     <= 1'b0;
      inverted       <= 1'b0;
      contrast       <= CONTRAST_RESET;
      charge_pump_en <= 1'b0;
    end else if (cmd_strobe) begin
      case (dec_state)
        DEC_IDLE: begin
          case (push_data)
            CMD_DISPLAY_OFF:  display_on <= 1'b0;
            CMD_DISPLAY_ON:   display_on <= 1'b1;
            CMD_NORMAL:       inverted   <= 1'b0;
            CMD_INVERT:       inverted   <= 1'b1;
            CMD_SET_CONTRAST: dec_state  <= DEC_ARG_CONTRAST;
            CMD_CHARGE_PUMP:  dec_state  <= DEC_ARG_PUMP;
            default: begin
              if (takes_skip_arg(push_data)) dec_state <= DEC_ARG_SKIP;
            end
          endcase
        end
        DEC_ARG_CONTRAST: begin
          contrast  <= push_data;
          dec_state <= DEC_IDLE;
        end
        DEC_ARG_PUMP: begin
          charge_pump_en <= push_data[2];
          dec_state      <= DEC_IDLE;
        end
        default: dec_state <= DEC_IDLE;
      endcase
    end
  end

endmodule
